// File: rtl/onehot_scan_sequencer.sv
// Steps a binary channel select through the enabled channels of a mask, holding each
// for a programmable settle time and handshaking a sample request before moving on.
module onehot_scan_sequencer #(
  parameter int SEL_WIDTH   = 4,
  parameter int SEL_COUNT   = 2 ** SEL_WIDTH,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [SEL_COUNT-1:0]   ch_mask,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [SEL_WIDTH-1:0]   sel,
  output logic                   sel_valid,
  output logic                   sample_req,
  input  logic                   sample_ack,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;

  logic [1:0]             state;
  logic [SEL_COUNT-1:0]   mask_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [DWELL_WIDTH-1:0] cnt;

  logic                   next_found;
  logic [SEL_WIDTH-1:0]   next_sel;
  logic [SEL_WIDTH-1:0]   first_sel;

  // Descending loops so the lowest qualifying bit is the last (winning) assignment.
  always_comb begin
    next_found = 1'b0;
    next_sel   = '0;
    first_sel  = '0;
    for (int i = SEL_COUNT - 1; i >= 0; i--) begin
      if (mask_q[i] && (SEL_WIDTH'(i) > sel)) begin
        next_found = 1'b1;
        next_sel   = SEL_WIDTH'(i);
      end
      if (ch_mask[i]) begin
        first_sel = SEL_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      sel_valid  <= 1'b0;
      sample_req <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mask_q     <= '0;
      dwell_q    <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort leaves sel where it was so the decoder does not glitch.
        state      <= IDLE;
        sel_valid  <= 1'b0;
        sample_req <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (ch_mask != '0) begin
                mask_q    <= ch_mask;
                dwell_q   <= dwell;
                sel       <= first_sel;
                cnt       <= dwell;
                sel_valid <= 1'b1;
                busy      <= 1'b1;
                state     <= SETTLE;
              end else begin
                done <= 1'b1;
              end
            end
          end
          SETTLE: begin
            if (cnt == '0) begin
              state      <= SAMPLE;
              sample_req <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SAMPLE: begin
            if (sample_ack) begin
              sample_req <= 1'b0;
              if (next_found) begin
                sel   <= next_sel;
                cnt   <= dwell_q;
                state <= SETTLE;
              end else if (continuous && (ch_mask != '0)) begin
                mask_q  <= ch_mask;
                dwell_q <= dwell;
                sel     <= first_sel;
                cnt     <= dwell;
                state   <= SETTLE;
              end else begin
                if (continuous) begin
                  mask_q  <= ch_mask;
                  dwell_q <= dwell;
                end
                state     <= IDLE;
                done      <= 1'b1;
                sel_valid <= 1'b0;
                busy      <= 1'b0;
              end
            end
          end
          default: begin
            state      <= IDLE;
            sel_valid  <= 1'b0;
            sample_req <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onehot_scan_sequencer.sv
// Self-checking bench for onehot_scan_sequencer: a vector table plus hand-built scan
// sequences, with expected outputs queued at drive time and compared after each edge.
module tb_onehot_scan_sequencer;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        stop;
    logic        cont;
    logic        ack;
    logic [15:0] mask;
    logic [7:0]  dwell;
    logic [3:0]  esel;
    logic        ev;
    logic        er;
    logic        eb;
    logic        ed;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [15:0] ch_mask;
  logic [7:0]  dwell;
  logic [3:0]  sel;
  logic        sel_valid;
  logic        sample_req;
  logic        sample_ack;
  logic        busy;
  logic        done;

  int          checks;
  int          failures;
  string       tag;
  logic [7:0]  expq[$];
  vec_t        tbl[28];

  onehot_scan_sequencer #(
    .SEL_WIDTH(4),
    .SEL_COUNT(16),
    .DWELL_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .continuous(continuous),
    .ch_mask(ch_mask),
    .dwell(dwell),
    .sel(sel),
    .sel_valid(sel_valid),
    .sample_req(sample_req),
    .sample_ack(sample_ack),
    .busy(busy),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic st, input logic sp, input logic c,
                              input logic a, input logic [15:0] m, input logic [7:0] d,
                              input logic [3:0] es, input logic ev, input logic er,
                              input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.cont = c; v.ack = a;
    v.mask = m; v.dwell = d;
    v.esel = es; v.ev = ev; v.er = er; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic checkOutput();
    logic [7:0] exp;
    logic [7:0] act;
    act = {sel, sel_valid, sample_req, busy, done};
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", tag, act);
    end else begin
      exp = expq.pop_front();
      if (act !== exp) begin
        failures++;
        $display("[TB] FAIL %s: got sel=%0d valid=%b req=%b busy=%b done=%b, expected sel=%0d valid=%b req=%b busy=%b done=%b",
                 tag, act[7:4], act[3], act[2], act[1], act[0],
                 exp[7:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    start      = v.start;
    stop       = v.stop;
    continuous = v.cont;
    sample_ack = v.ack;
    ch_mask    = v.mask;
    dwell      = v.dwell;
    expq.push_back({v.esel, v.ev, v.er, v.eb, v.ed});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //                rst st sp c  a  mask      dwell  sel  v  r  b  d
    tbl[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 8'd0, 4'd0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 16'h0000, 8'd0, 4'd0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 16'h0000, 8'd0, 4'd0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 16'h0000, 8'd0, 4'd0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 16'h000F, 8'd1, 4'd0, 1, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 16'h000F, 8'd1, 4'd0, 1, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 16'h000F, 8'd1, 4'd0, 1, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 16'h000F, 8'd1, 4'd1, 1, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 16'h000F, 8'd1, 4'd1, 1, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 16'h000F, 8'd1, 4'd1, 1, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 16'h000F, 8'd1, 4'd2, 1, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 16'h000F, 8'd1, 4'd2, 1, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 16'h000F, 8'd1, 4'd2, 1, 1, 1, 0);
    tbl[13] = mk(0, 0, 1, 0, 1, 16'h000F, 8'd1, 4'd2, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 16'h000F, 8'd1, 4'd2, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 16'h000F, 8'd1, 4'd0, 1, 0, 1, 0);
    tbl[16] = mk(0, 0, 1, 0, 0, 16'h000F, 8'd1, 4'd0, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 1, 0, 0, 16'h000F, 8'd1, 4'd0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 1, 16'h000F, 8'd1, 4'd0, 0, 0, 0, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 16'h8000, 8'd0, 4'd15, 1, 0, 1, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 16'h8000, 8'd0, 4'd15, 1, 1, 1, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 16'h8000, 8'd0, 4'd15, 1, 1, 1, 0);
    tbl[22] = mk(0, 1, 0, 0, 1, 16'h8000, 8'd0, 4'd15, 0, 0, 0, 1);
    tbl[23] = mk(0, 0, 0, 0, 0, 16'h8000, 8'd0, 4'd15, 0, 0, 0, 0);
    tbl[24] = mk(0, 1, 0, 0, 0, 16'h0080, 8'd3, 4'd7, 1, 0, 1, 0);
    tbl[25] = mk(1, 0, 0, 0, 0, 16'h0080, 8'd3, 4'd0, 0, 0, 0, 0);
    tbl[26] = mk(1, 0, 0, 0, 0, 16'h0080, 8'd3, 4'd0, 0, 0, 0, 0);
    tbl[27] = mk(0, 0, 0, 0, 0, 16'h0080, 8'd3, 4'd0, 0, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      tag = $sformatf("table_row%0d", i);
      applyStimulus(tbl[i]);
    end

    // Single pass over 0x0091, dwell 3, ack one cycle after each request.
    begin
      int chans[3];
      chans = '{0, 4, 7};
      tag = "pass91_start";
      applyStimulus(mk(0, 1, 0, 0, 0, 16'h0091, 8'd3, 4'd0, 1, 0, 1, 0));
      for (int k = 0; k < 3; k++) begin
        for (int s = 0; s < 3; s++) begin
          tag = $sformatf("pass91_ch%0d_settle%0d", chans[k], s);
          applyStimulus(mk(0, 0, 0, 0, 0, 16'h0091, 8'd3, 4'(chans[k]), 1, 0, 1, 0));
        end
        tag = $sformatf("pass91_ch%0d_req", chans[k]);
        applyStimulus(mk(0, 0, 0, 0, 0, 16'h0091, 8'd3, 4'(chans[k]), 1, 1, 1, 0));
        tag = $sformatf("pass91_ch%0d_hold", chans[k]);
        applyStimulus(mk(0, 0, 0, 0, 0, 16'h0091, 8'd3, 4'(chans[k]), 1, 1, 1, 0));
        tag = $sformatf("pass91_ch%0d_ack", chans[k]);
        if (k < 2)
          applyStimulus(mk(0, 0, 0, 0, 1, 16'h0091, 8'd3, 4'(chans[k+1]), 1, 0, 1, 0));
        else
          applyStimulus(mk(0, 0, 0, 0, 1, 16'h0091, 8'd3, 4'd7, 0, 0, 0, 1));
      end
      tag = "pass91_idle";
      applyStimulus(mk(0, 0, 0, 0, 0, 16'h0091, 8'd3, 4'd7, 0, 0, 0, 0));
    end

    // Continuous single-channel wrap with ack held high throughout.
    tag = "wrap15_start";
    applyStimulus(mk(0, 1, 0, 1, 1, 16'h8000, 8'd0, 4'd15, 1, 0, 1, 0));
    for (int k = 0; k < 4; k++) begin
      tag = $sformatf("wrap15_req%0d", k);
      applyStimulus(mk(0, 0, 0, 1, 1, 16'h8000, 8'd0, 4'd15, 1, 1, 1, 0));
      tag = $sformatf("wrap15_reload%0d", k);
      applyStimulus(mk(0, 0, 0, 1, 1, 16'h8000, 8'd0, 4'd15, 1, 0, 1, 0));
    end
    tag = "wrap15_lastreq";
    applyStimulus(mk(0, 0, 0, 0, 1, 16'h8000, 8'd0, 4'd15, 1, 1, 1, 0));
    tag = "wrap15_done";
    applyStimulus(mk(0, 0, 0, 0, 1, 16'h8000, 8'd0, 4'd15, 0, 0, 0, 1));
    tag = "wrap15_idle";
    applyStimulus(mk(0, 0, 0, 0, 0, 16'h8000, 8'd0, 4'd15, 0, 0, 0, 0));

    // Mid-pass mask/dwell change is ignored until the wrap picks it up.
    tag = "midchg_start";
    applyStimulus(mk(0, 1, 0, 1, 0, 16'h0011, 8'd2, 4'd0, 1, 0, 1, 0));
    for (int s = 0; s < 2; s++) begin
      tag = $sformatf("midchg_ch0_settle%0d", s);
      applyStimulus(mk(0, 0, 0, 1, 0, 16'hFFFF, 8'd0, 4'd0, 1, 0, 1, 0));
    end
    tag = "midchg_ch0_req";
    applyStimulus(mk(0, 0, 0, 1, 0, 16'hFFFF, 8'd0, 4'd0, 1, 1, 1, 0));
    tag = "midchg_ch0_ack";
    applyStimulus(mk(0, 0, 0, 1, 1, 16'hFFFF, 8'd0, 4'd4, 1, 0, 1, 0));
    for (int s = 0; s < 2; s++) begin
      tag = $sformatf("midchg_ch4_settle%0d", s);
      applyStimulus(mk(0, 0, 0, 1, 0, 16'hFFFF, 8'd0, 4'd4, 1, 0, 1, 0));
    end
    tag = "midchg_ch4_req";
    applyStimulus(mk(0, 0, 0, 1, 0, 16'hFFFF, 8'd0, 4'd4, 1, 1, 1, 0));
    tag = "midchg_wrap";
    applyStimulus(mk(0, 0, 0, 1, 1, 16'hFFFF, 8'd0, 4'd0, 1, 0, 1, 0));
    for (int c = 0; c < 16; c++) begin
      tag = $sformatf("full_ch%0d_req", c);
      applyStimulus(mk(0, 0, 0, 1, 0, 16'hFFFF, 8'd0, 4'(c), 1, 1, 1, 0));
      tag = $sformatf("full_ch%0d_ack", c);
      if (c < 15)
        applyStimulus(mk(0, 0, 0, 1, 1, 16'hFFFF, 8'd0, 4'(c + 1), 1, 0, 1, 0));
      else
        applyStimulus(mk(0, 0, 0, 0, 1, 16'hFFFF, 8'd0, 4'd15, 0, 0, 0, 1));
    end
    tag = "full_idle";
    applyStimulus(mk(0, 0, 0, 0, 0, 16'hFFFF, 8'd0, 4'd15, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_scan_sequencer.md
Name: onehot_scan_sequencer

Overview:
Sequencer that drives the binary select of a binary-to-one-hot decoder. It steps through the enabled channels in ascending order and holds each channel for a programmable settle time. It then issues a sample request and waits for the capture logic to acknowledge before moving on. It supports single-pass and continuous scanning and sits between the host control registers and the channel decoder/measurement path in the playground.

Parameters:
SEL_WIDTH, 4, width of the binary select output (must be >0)
SEL_COUNT, 2**SEL_WIDTH, number of channels (width of the channel mask)
DWELL_WIDTH, 8, width of the settle-time counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  begin a scan (pulse; level is accepted too, evaluated only in IDLE)
stop  input  1  abort the scan synchronously
continuous  input  1  1 = wrap and rescan after each pass; evaluated at end of every pass
ch_mask  input  SEL_COUNT  channel enable mask (bit i = channel i); captured at pass start
dwell  input  DWELL_WIDTH  settle cycles; captured at pass start
sel  output  SEL_WIDTH  binary channel select to the decoder
sel_valid  output  1  sel is driving an active channel
sample_req  output  1  settle complete, capture requested
sample_ack  input  1  capture done, sampled together with sample_req
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at the end of a completed single pass

Behaviour:
- Reset is synchronous and active-high. After reset: state=IDLE, sel=0, sel_valid=0, sample_req=0, busy=0, done=0, mask_q=0, cnt=0.
- Priority order: rst > stop > start/ack/counter events.
- States are IDLE, SETTLE and SAMPLE. All outputs are registered.
- IDLE, start=1, ch_mask!=0:
  - capture mask_q=ch_mask and dwell_q=dwell
  - set sel = lowest set bit of ch_mask and cnt=dwell
  - set sel_valid=1 and busy=1, enter SETTLE
  - all of this is visible the cycle after start.
- IDLE, start=1, ch_mask==0: stay in IDLE, pulse done the next cycle, sel_valid stays 0.
- SETTLE:
  - if cnt==0, enter SAMPLE and assert sample_req; otherwise decrement cnt
  - SETTLE therefore lasts dwell_q+1 cycles, and sample_req rises dwell_q+1 cycles after sel changes.
- SAMPLE: sample_req is held high until sample_ack=1. In the ack cycle:
  - If a set bit of mask_q exists above sel: set sel to the next higher set bit, cnt=dwell_q, enter SETTLE, clear sample_req.
  - Else if continuous=1: recapture mask_q=ch_mask and dwell_q=dwell.
    - If the new mask is nonzero: sel = its lowest set bit, enter SETTLE.
    - If the new mask is zero: behave as the end of a single pass.
  - Else (end of pass): enter IDLE, pulse done next cycle, set sel_valid=0, sample_req=0, busy=0.
- Wrap-around with a single enabled channel in continuous mode: the same sel is reloaded and SETTLE restarts. sel_valid stays 1.
- sel holds stable whenever sel_valid=1. In IDLE, sel keeps its last value.
- sample_ack outside SAMPLE is ignored.
- start while busy is ignored.
- Changes to ch_mask or dwell mid-pass have no effect until the next pass boundary.
- stop in any state: next cycle state=IDLE, sel_valid=0, sample_req=0, busy=0. No done pulse. sel is unchanged.
- stop and sample_ack in the same cycle: stop wins and the sample is discarded.
- rst mid-scan returns every output to its reset value on the next edge.
- Channel search is combinational priority logic over mask_q, from sel+1 upward (next channel) or from bit 0 (first channel). No arithmetic overflow is possible: when sel=SEL_COUNT-1 the "above" set is empty.

Test Plan:
- Reset held 2 cycles mid-scan -> sel=0, sel_valid=0, sample_req=0, busy=0, done=0 on the first cycle after rst.
- ch_mask=16'h0091, dwell=3, continuous=0, ack one cycle after each req:
  - sel visits 0, 4, 7
  - each req rises 4 cycles after its sel change
  - done pulses once after the ack on channel 7, then busy=0.
- ch_mask=16'h8000, dwell=0, continuous=1, ack immediate:
  - sel stays 15 and req pulses every 2 cycles
  - drop continuous -> done after the next ack.
- start with ch_mask=0 -> busy stays 0, done=1 for exactly one cycle, sel_valid=0.
- Mid-SETTLE change ch_mask to 16'hFFFF -> current pass still follows the original mask; with continuous=1 the next pass visits 0..15.
- stop asserted in the same cycle as sample_ack on channel 2 of mask 16'h000F:
  - next cycle IDLE, sel=2, sel_valid=0, no done
  - a new start restarts at channel 0.
